// File: rtl/inv_key_schedule_if.sv
// Purpose: bundles the key-schedule request/response signals between the
//          decryption controller (master) and inv_key_schedule (slave).
// Signals:
//   load      master->slave  pulse: capture key_in, start forward expansion
//   key_in    master->slave  128-bit cipher key, byte 0 at [127:120]
//   next      master->slave  pulse: step back to the previous round key
//   round_key slave->master  current round key (registered)
//   round_idx slave->master  round number of round_key (10..0)
//   key_valid slave->master  round_key/round_idx may be consumed
//   busy      slave->master  forward expansion in progress
//   last      slave->master  key_valid and round_idx==0
interface inv_key_schedule_if;
   logic         load;
   logic [127:0] key_in;
   logic         next;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         busy;
   logic         last;

   modport master (
      output load, key_in, next,
      input  round_key, round_idx, key_valid, busy, last
   );

   modport slave (
      input  load, key_in, next,
      output round_key, round_idx, key_valid, busy, last
   );
endinterface

// File: rtl/inv_key_schedule.sv
// Purpose: iterative AES-128 round-key generator for the decryption path.
//          Expands the cipher key forward to round key 10, then walks back
//          one round key per next request using the inverse recursion, so
//          no table of round keys is stored.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  inv_key_schedule_if.slave (load/key_in/next in, key outputs out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no key loaded; outputs cleared, next ignored
// S_EXPAND | one forward step per cycle until round key NR is held
// S_SERVE  | round_key valid; next steps back one round down to 0
module inv_key_schedule #(
   parameter int NR = 10
) (
   input logic                clk,
   input logic                rst,
   inv_key_schedule_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_SERVE} state_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   state_t       r_state;
   state_t       w_state_nxt;
   logic [127:0] r_key;
   logic [7:0]   r_rcon;
   logic [3:0]   r_cnt;
   logic [3:0]   r_idx;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3;
   logic [31:0]  w_p1, w_p2, w_p3, w_p0;
   logic [31:0]  w_n0, w_n1, w_n2, w_n3;
   logic [31:0]  w_sub_in, w_sub_out;
   logic [7:0]   w_rcon_fwd, w_rcon_bwd;
   logic         w_last_step;
   logic         w_step_back;

   assign w_w0 = r_key[127:96];
   assign w_w1 = r_key[95:64];
   assign w_w2 = r_key[63:32];
   assign w_w3 = r_key[31:0];

   // Backward words: p3 is recovered first because it feeds the shared SubWord.
   assign w_p3 = w_w3 ^ w_w2;
   assign w_p2 = w_w2 ^ w_w1;
   assign w_p1 = w_w1 ^ w_w0;

   // One SubWord shared by both directions; EXPAND uses w3, SERVE uses p3.
   assign w_sub_in  = (r_state == S_EXPAND) ? {w_w3[23:0], w_w3[31:24]}
                                            : {w_p3[23:0], w_p3[31:24]};
   assign w_sub_out = {SBOX[w_sub_in[31:24]], SBOX[w_sub_in[23:16]],
                       SBOX[w_sub_in[15:8]],  SBOX[w_sub_in[7:0]]};

   assign w_n0 = w_w0 ^ w_sub_out ^ {r_rcon, 24'h0};
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;
   assign w_p0 = w_w0 ^ w_sub_out ^ {r_rcon, 24'h0};

   // Inverse of xtime over the rcon sequence: 0x1b came from 0x80.
   assign w_rcon_fwd = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
   assign w_rcon_bwd = (r_rcon == 8'h1b) ? 8'h80 : {1'b0, r_rcon[7:1]};

   assign w_last_step = (r_cnt == 4'(NR - 1));
   assign w_step_back = (r_state == S_SERVE) && !bus.load && bus.next &&
                        (r_idx != 4'd0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (bus.load) w_state_nxt = S_EXPAND;
         S_EXPAND: if (!bus.load && w_last_step) w_state_nxt = S_SERVE;
         S_SERVE:  if (bus.load) w_state_nxt = S_EXPAND;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key  <= '0;
         r_rcon <= 8'h01;
         r_cnt  <= '0;
         r_idx  <= '0;
      end else if (bus.load) begin
         r_key  <= bus.key_in;
         r_rcon <= 8'h01;
         r_cnt  <= '0;
      end else if (r_state == S_EXPAND) begin
         r_key <= {w_n0, w_n1, w_n2, w_n3};
         r_cnt <= r_cnt + 4'd1;
         if (w_last_step) begin
            // rcon(NR) is what the first backward step needs.
            r_rcon <= 8'h36;
            r_idx  <= 4'(NR);
         end else begin
            r_rcon <= w_rcon_fwd;
         end
      end else if (w_step_back) begin
         r_key  <= {w_p0, w_p1, w_p2, w_p3};
         r_rcon <= w_rcon_bwd;
         r_idx  <= r_idx - 4'd1;
      end
   end

   assign bus.round_key = r_key;
   assign bus.round_idx = r_idx;
   assign bus.key_valid = (r_state == S_SERVE);
   assign bus.busy      = (r_state == S_EXPAND);
   assign bus.last      = (r_state == S_SERVE) && (r_idx == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: reference model keeps the loaded key and the
// served round number, and derives each expected round key with a full
// word-by-word AES-128 key expansion from an S-box built from GF(2^8) math.
module tb_inv_key_schedule;

   localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K_TWO   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] RK10_F  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK9_F   = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] RK1_F   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK10_T  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic clk;
   logic rst;
   inv_key_schedule_if bus();

   inv_key_schedule #(.NR(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] tb_sbox [0:255];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
   endfunction

   // Round key n of the standard 44-word AES-128 expansion.
   function automatic logic [127:0] rk_of(input logic [127:0] k, input int n);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   initial begin
      logic [7:0] inv;
      for (int b = 0; b < 256; b++) begin
         inv = 8'h00;
         for (int x = 1; x < 256; x++)
            if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
         tb_sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   end

   // Model: 0 idle, 1 expanding, 2 serving.
   int           m_mode;
   int           m_cnt;
   int           m_idx;
   logic [127:0] m_key;
   bit           m_ready = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_mode <= 0; m_cnt <= 0; m_idx <= 0; m_key <= '0; m_ready <= 1'b1;
      end else if (bus.load) begin
         m_mode <= 1; m_cnt <= 0; m_key <= bus.key_in;
      end else if (m_mode == 1) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == 9) begin
            m_mode <= 2; m_idx <= 10;
         end
      end else if (m_mode == 2 && bus.next && m_idx > 0) begin
         m_idx <= m_idx - 1;
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         chk("key_valid", bus.key_valid, (m_mode == 2));
         chk("busy", bus.busy, (m_mode == 1));
         chk("last", bus.last, (m_mode == 2 && m_idx == 0));
         if (m_mode != 1) begin
            chk("round_idx", bus.round_idx, m_idx);
            chk("round_key", bus.round_key, (m_mode == 2) ? rk_of(m_key, m_idx) : 128'h0);
         end
      end
   end

   task automatic load_and_wait(input logic [127:0] k, input bit hold_next, input int hold_idx);
      int n;
      n = 0;
      bus.load = 1'b1; bus.key_in = k;
      if (hold_next) bus.next = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      if (hold_idx >= 0) begin
         chk("prio_busy", bus.busy, 1);
         chk("prio_idx_kept", bus.round_idx, hold_idx);
      end
      for (int i = 0; i < 30 && !bus.key_valid; i++) begin
         if (bus.busy) n++;
         if (n >= 9) bus.next = 1'b0;
         @(negedge clk);
      end
      bus.next = 1'b0;
      chk("expand_done", bus.key_valid, 1);
      chk("busy_cycles", n, 10);
      chk("idx_after_expand", bus.round_idx, 10);
   endtask

   task automatic step_to(input int target);
      bus.next = 1'b1;
      for (int i = 0; i < 12 && bus.round_idx != 4'(target); i++) @(negedge clk);
      bus.next = 1'b0;
      chk("step_to", bus.round_idx, target);
   endtask

   initial begin
      rst = 1'b1; bus.load = 1'b0; bus.next = 1'b0; bus.key_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", bus.key_valid, 0);
      chk("rst_key", bus.round_key, 0);

      chk("model_sbox00", tb_sbox[0], 8'h63);
      chk("model_sbox53", tb_sbox[8'h53], 8'hed);
      chk("model_rk10", rk_of(K_FIPS, 10), RK10_F);
      chk("model_rk1", rk_of(K_FIPS, 1), RK1_F);

      load_and_wait(K_FIPS, 1'b0, -1);
      chk("fips_rk10", bus.round_key, RK10_F);
      bus.next = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1)  chk("fips_rk9", bus.round_key, RK9_F);
         if (k == 9)  chk("fips_rk1", bus.round_key, RK1_F);
         if (k == 10) chk("fips_rk0_last", bus.last, 1);
         if (k == 12) begin
            chk("fips_rk0_hold", bus.round_key, K_FIPS);
            chk("fips_idx0_hold", bus.round_idx, 0);
         end
      end
      bus.next = 1'b0;

      load_and_wait(K_TWO, 1'b0, -1);
      chk("two_rk10", bus.round_key, RK10_T);
      step_to(0);
      chk("two_rk0", bus.round_key, K_TWO);

      // Restart mid-expansion at cnt=5.
      bus.load = 1'b1; bus.key_in = K_TWO;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (4) @(negedge clk);
      load_and_wait(K_FIPS, 1'b0, -1);
      chk("restart_exp_rk10", bus.round_key, RK10_F);

      step_to(4);
      load_and_wait(K_FIPS, 1'b0, -1);
      chk("restart_srv_rk10", bus.round_key, RK10_F);

      // load+next together in SERVE, next held through expansion.
      step_to(9);
      load_and_wait(K_TWO, 1'b1, 9);
      chk("prio_rk10", bus.round_key, RK10_T);

      // Reset in SERVE, then next in IDLE.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_srv_key", bus.round_key, 0);
      chk("rst_srv_valid", bus.key_valid, 0);
      bus.next = 1'b1;
      repeat (3) @(negedge clk);
      bus.next = 1'b0;
      chk("idle_next_valid", bus.key_valid, 0);

      // Reset during EXPAND.
      bus.load = 1'b1; bus.key_in = K_FIPS;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_exp_busy", bus.busy, 0);
      chk("rst_exp_key", bus.round_key, 0);
      @(negedge clk);

      load_and_wait(K_FIPS, 1'b0, -1);
      chk("post_rst_rk10", bus.round_key, RK10_F);
      step_to(0);
      chk("post_rst_rk0", bus.round_key, K_FIPS);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Iterative AES-128 round-key generator for the decryption datapath; it sits directly upstream of the inverse mid/final round stages and drives their 128-bit key input.
- Takes the cipher key, expands it forward to round key 10, then serves keys 10 down to 0, one step per `next` request, using on-the-fly backward recursion. No 11-entry key RAM.

Parameters:
- NR, 10, number of AES rounds (fixed for AES-128; widths below assume 10).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  pulse: capture key_in and start expansion
- key_in  input  128  cipher key, byte 0 at [127:120]
- next  input  1  pulse: step to the previous round key
- round_key  output  128  current round key (registered)
- round_idx  output  4  index of round_key (10..0)
- key_valid  output  1  round_key/round_idx valid for consumption
- busy  output  1  forward expansion in progress
- last  output  1  key_valid and round_idx==0

Behaviour:
- Word layout: w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0]. RotWord(x)={x[23:0],x[31:24]}. SubWord applies the forward AES S-box to each of 4 bytes. Rcon is XORed into the MSB byte only.
- Forward step, with rcon r: n0=w0^SubWord(RotWord(w3))^{r,24'h0}; n1=w1^n0; n2=w2^n1; n3=w3^n2. After the step, r = xtime(r): r<<1, XOR 0x1b if r[7] was set.
- Backward step, from round i to i-1, with r=rcon(i): p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^{r,24'h0}. After the step, r = (r==8'h1b) ? 8'h80 : r>>1.
- Only one SubWord instance is needed (4 S-boxes), muxed between the forward and backward paths.
- States:
  - IDLE: key_valid=0, busy=0.
  - load -> key register=key_in, rcon=0x01, cnt=0, go to EXPAND.
  - next is ignored.
- EXPAND: busy=1, key_valid=0.
  - Each cycle performs one forward step and cnt++.
  - On the edge where cnt reaches 10: go to SERVE, round_idx=10, rcon=0x36.
  - Load asserted during EXPAND restarts from key_in (cnt=0, rcon=0x01).
  - next is ignored.
- SERVE: key_valid=1, busy=0.
  - next with round_idx>0: one backward step, round_idx--, effective on the next edge. The result is visible the cycle after the next edge.
  - next with round_idx==0: ignored. State, key and rcon are unchanged.
  - load re-enters EXPAND with the new key.
  - load and next in the same cycle: load wins, next is dropped.
  - There is no automatic return to IDLE. SERVE holds until load or rst.
- Latency:
  - load sampled at edge E; busy is high from after E through edge E+10.
  - key_valid rises after edge E+10, with round_key = round-10 key.
  - Each next produces the new key 1 cycle later, so one key per cycle with next held high.
- Reset (rst=1 at an edge, in any state including mid-EXPAND):
  - state=IDLE, round_key=0, round_idx=0, key_valid=0, busy=0, last=0.
  - rcon=0x01, cnt=0.
  - rst has priority over load and next.
- Outputs are registers or decodes of state only; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic expansion: rst, then load key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy high for 10 cycles, then key_valid=1, round_idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backward sequence: continue with next held high -> round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e1516...4f3c with last=1. A further next leaves all outputs unchanged.
- Second key: load 000102030405060708090a0b0c0d0e0f -> round-10 key 13111d7fe3944a17f307a78b4d2b30c5. Stepping back to round 0 returns 000102...0f, which confirms the rcon inverse wraps correctly through 0x1b->0x80.
- Restart: load during EXPAND at cnt=5 with the FIPS key, and separately load in SERVE at round_idx=4 -> a fresh 10-cycle expansion each time, ending at round_key d014f9a8....
- Priority: load and next asserted together in SERVE -> EXPAND entered and round_idx not decremented. next in IDLE or EXPAND -> no effect.
- Reset mid-operation: rst asserted during EXPAND and during SERVE -> on the next edge all outputs are 0 and state is IDLE. A subsequent load behaves as in the first scenario.
